// File: rtl/lcd_frame_buffer.sv
`timescale 1ns/1ps
// Double-buffered 32-character frame store feeding the 16x2 LCD driver.
// Characters are composed in a back buffer and published to data_out on commit.
module lcd_frame_buffer #(
  parameter logic [7:0] CLEAR_CHAR     = 8'h20,
  parameter int         REFRESH_CYCLES = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_char,
  input  logic         clear_req,
  input  logic         commit_req,
  output logic         busy,
  output logic         commit_done,
  output logic         lcd_refresh,
  output logic [255:0] data_out
);

  typedef enum logic [1:0] {IDLE, CLEAR, REFRESH} state_t;

  localparam logic [3:0] REF_LOAD = 4'(REFRESH_CYCLES - 1);

  state_t       state_reg, state_next;
  logic [4:0]   clr_idx_reg, clr_idx_next;
  logic [3:0]   ref_cnt_reg, ref_cnt_next;
  logic [7:0]   back_reg [32];
  logic [255:0] merged_frame;
  logic         buf_we;
  logic [4:0]   buf_addr;
  logic [7:0]   buf_data;
  logic         load_front;
  logic         commit_done_next;
  logic         lcd_refresh_next;

  // Commit snapshot with any same-cycle write folded in.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_merge
      assign merged_frame[255-8*gi -: 8] =
        (wr_en && wr_addr == 5'(gi)) ? wr_char : back_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    clr_idx_next     = clr_idx_reg;
    ref_cnt_next     = ref_cnt_reg;
    buf_we           = 1'b0;
    buf_addr         = wr_addr;
    buf_data         = wr_char;
    load_front       = 1'b0;
    commit_done_next = 1'b0;
    lcd_refresh_next = lcd_refresh;
    case (state_reg)
      IDLE: begin
        lcd_refresh_next = 1'b0;
        if (clear_req) begin
          state_next   = CLEAR;
          clr_idx_next = 5'd0;
        end else if (commit_req) begin
          buf_we           = wr_en;
          load_front       = 1'b1;
          commit_done_next = 1'b1;
          lcd_refresh_next = 1'b1;
          ref_cnt_next     = REF_LOAD;
          state_next       = REFRESH;
        end else begin
          buf_we = wr_en;
        end
      end
      CLEAR: begin
        buf_we       = 1'b1;
        buf_addr     = clr_idx_reg;
        buf_data     = CLEAR_CHAR;
        clr_idx_next = clr_idx_reg + 5'd1;
        if (clr_idx_reg == 5'd31) state_next = IDLE;
      end
      REFRESH: begin
        // Next frame may be composed while the LCD driver restarts.
        buf_we = wr_en;
        if (ref_cnt_reg == 4'd0) begin
          lcd_refresh_next = 1'b0;
          state_next       = IDLE;
        end else begin
          ref_cnt_next = ref_cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      clr_idx_reg <= 5'd0;
      ref_cnt_reg <= 4'd0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      lcd_refresh <= 1'b0;
      data_out    <= {32{CLEAR_CHAR}};
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
      ref_cnt_reg <= ref_cnt_next;
      busy        <= (state_next != IDLE);
      commit_done <= commit_done_next;
      lcd_refresh <= lcd_refresh_next;
      if (load_front) data_out <= merged_frame;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) back_reg[i] <= CLEAR_CHAR;
    end else if (buf_we) begin
      back_reg[buf_addr] <= buf_data;
    end
  end

endmodule

// File: tb/tb_lcd_frame_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for lcd_frame_buffer: table-driven commits against a
// reference character array, plus hand-written clear/refresh/reset sequences.
module tb_lcd_frame_buffer;

  localparam logic [255:0] SPACES = {32{8'h20}};

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [7:0]   wr_char = '0;
  logic         clear_req = 1'b0;
  logic         commit_req = 1'b0;
  logic         busy, commit_done, lcd_refresh;
  logic [255:0] data_out;

  int errors = 0;
  int checks = 0;
  logic [7:0]   model [32];
  logic [255:0] exp_q [$];

  typedef struct {
    logic [4:0] addr;
    logic [7:0] ch;
    bit         merge;
    int         exp_msb;
  } vec_t;

  vec_t vecs [5];

  lcd_frame_buffer dut (
    .clock(clock), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .clear_req(clear_req), .commit_req(commit_req),
    .busy(busy), .commit_done(commit_done), .lcd_refresh(lcd_refresh),
    .data_out(data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] frame_of();
    logic [255:0] f;
    for (int k = 0; k < 32; k++) f[255-8*k -: 8] = model[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) model[k] = 8'h20;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    tick();
    wr_en = 1'b0;
    model[a] = c;
    $display("write addr=%0d char=%h", a, c);
  endtask

  // Issue a commit (optionally with a same-cycle write), check the published
  // frame through the scoreboard, then measure the refresh pulse.
  task automatic do_commit(input bit merge, input logic [4:0] a, input logic [7:0] c);
    int cnt_ref, cnt_done;
    if (merge) begin
      wr_en = 1'b1; wr_addr = a; wr_char = c;
      model[a] = c;
    end
    commit_req = 1'b1;
    exp_q.push_back(frame_of());
    tick();
    commit_req = 1'b0;
    wr_en = 1'b0;
    check("commit_done_pulse", 256'(commit_done), 256'd1);
    check("busy_on_commit", 256'(busy), 256'd1);
    if (commit_done && exp_q.size() > 0) check("frame", data_out, exp_q.pop_front());
    else exp_q.delete();
    cnt_ref = lcd_refresh ? 1 : 0;
    cnt_done = 0;
    for (int i = 0; i < 20 && lcd_refresh; i++) begin
      tick();
      if (lcd_refresh) cnt_ref++;
      if (commit_done) cnt_done++;
    end
    check("refresh_cycles", 256'(cnt_ref), 256'd4);
    check("done_single", 256'(cnt_done), 256'd0);
    check("busy_after_refresh", 256'(busy), 256'd0);
    $display("commit merge=%0b refresh_cycles=%0d data_out=%h", merge, cnt_ref, data_out);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, data_out, SPACES);
    check({tag, "_busy"}, 256'(busy), 256'd0);
    check({tag, "_refresh"}, 256'(lcd_refresh), 256'd0);
    check({tag, "_done"}, 256'(commit_done), 256'd0);
  endtask

  initial begin
    logic [255:0] held;
    int cnt_busy, cnt_done;

    vecs[0] = '{addr: 5'd5,  ch: 8'h41, merge: 1'b1, exp_msb: 215};
    vecs[1] = '{addr: 5'd0,  ch: 8'h2A, merge: 1'b0, exp_msb: 255};
    vecs[2] = '{addr: 5'd31, ch: 8'h7E, merge: 1'b1, exp_msb: 7};
    vecs[3] = '{addr: 5'd16, ch: 8'h58, merge: 1'b0, exp_msb: 127};
    vecs[4] = '{addr: 5'd15, ch: 8'h31, merge: 1'b1, exp_msb: 135};

    model_reset();
    #12 rst = 1'b1;
    repeat (5) tick();
    check_reset_outputs("reset");
    $display("reset idle data_out=%h busy=%0b", data_out, busy);

    // "HI" at 0,1 and 'Z' at 31
    write_char(5'd0, 8'h48);
    write_char(5'd1, 8'h49);
    write_char(5'd31, 8'h5A);
    check("write_no_output_change", data_out, SPACES);
    do_commit(1'b0, 5'd0, 8'h00);
    check("hi_slice", 256'(data_out[255:240]), 256'h4849);
    check("z_slice", 256'(data_out[7:0]), 256'h5A);

    for (int v = 0; v < 5; v++) begin
      if (!vecs[v].merge) write_char(vecs[v].addr, vecs[v].ch);
      do_commit(vecs[v].merge, vecs[v].addr, vecs[v].ch);
      check($sformatf("vec%0d_slice", v), 256'(data_out[vecs[v].exp_msb -: 8]), 256'(vecs[v].ch));
    end

    // Clear with writes hammered throughout; all must be dropped.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt_busy = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_char = 8'($urandom_range(8'h41, 8'h5A));
      tick();
      if (busy) cnt_busy++;
      else break;
    end
    wr_en = 1'b0;
    model_reset();
    check("clear_busy_cycles", 256'(cnt_busy), 256'd32);
    $display("clear busy_cycles=%0d", cnt_busy);
    do_commit(1'b0, 5'd0, 8'h00);
    check("clear_frame", data_out, SPACES);

    // Commit, then try to write and re-commit during REFRESH.
    write_char(5'd2, 8'h4B);
    commit_req = 1'b1;
    exp_q.push_back(frame_of());
    held = frame_of();
    tick();
    commit_req = 1'b0;
    if (commit_done && exp_q.size() > 0) check("refresh_frame", data_out, exp_q.pop_front());
    else begin
      check("refresh_commit_done", 256'(commit_done), 256'd1);
      exp_q.delete();
    end
    wr_en = 1'b1; wr_addr = 5'd16; wr_char = 8'h58; commit_req = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0;
    model[16] = 8'h58;
    cnt_done = commit_done ? 1 : 0;
    for (int i = 0; i < 20 && lcd_refresh; i++) begin
      tick();
      if (commit_done) cnt_done++;
    end
    check("ignored_commit_done", 256'(cnt_done), 256'd0);
    check("ignored_commit_frame", data_out, held);
    $display("refresh-time commit ignored data_out=%h", data_out);
    do_commit(1'b0, 5'd0, 8'h00);
    check("refresh_write_slice", 256'(data_out[127:120]), 256'h58);

    // Reset mid-clear: whole buffer returns to spaces.
    write_char(5'd20, 8'h51);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_clear");
    #2 rst = 1'b1;
    model_reset();
    tick();
    do_commit(1'b0, 5'd0, 8'h00);
    check("rst_clear_frame", data_out, SPACES);

    // Reset mid-refresh: lcd_refresh must fall immediately.
    write_char(5'd3, 8'h44);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    check("pre_reset_refresh", 256'(lcd_refresh), 256'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst_refresh");
    #2 rst = 1'b1;
    model_reset();
    tick();
    do_commit(1'b0, 5'd0, 8'h00);
    check("rst_refresh_frame", data_out, SPACES);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_frame_buffer.md
# lcd_frame_buffer

Double-buffered 32-character frame store that sits directly upstream of the 16x2 character LCD driver. Game and control logic write ASCII bytes one at a time into a back buffer, then request a commit. On commit the block publishes the frame as the 256-bit character bus the LCD driver consumes, and pulses that driver's active-high reset so it re-runs its init-and-write sequence.

## Interface
- CLEAR_CHAR, 8'h20: fill byte used by reset and clear (ASCII space).
- REFRESH_CYCLES, 4: cycles `lcd_refresh` is held high after a commit (range 1..15).
- clock  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; all state returns to reset values immediately.
- wr_en  in  1  write strobe; one character per cycle.
- wr_addr  in  5  character position: 0-15 = line 1 left to right, 16-31 = line 2 left to right.
- wr_char  in  8  character code written at `wr_addr`.
- clear_req  in  1  fill the back buffer with CLEAR_CHAR.
- commit_req  in  1  copy the back buffer to `data_out` and refresh the LCD.
- busy  out  1  high while in CLEAR or REFRESH.
- commit_done  out  1  one-cycle pulse when `data_out` has just been updated.
- lcd_refresh  out  1  active-high; drives the LCD driver's `rst`.
- data_out  out  256  front buffer; position k occupies bits [255-8k : 248-8k].

## Operation
- Storage:
  - back buffer: 32 x 8-bit registers.
  - front buffer: `data_out`, a 256-bit register.
- FSM has 3 states: IDLE, CLEAR, REFRESH; a 5-bit `clr_idx` and a 4-bit `ref_cnt`.
- IDLE, requests handled with priority `clear_req` > `commit_req`:
  - `clear_req` goes to CLEAR with `clr_idx`=0. Any same-cycle `wr_en` and `commit_req` are dropped.
  - Otherwise `commit_req`: `data_out` <= back buffer, with a same-cycle write merged in (the written char appears in the committed frame). `commit_done` <= 1, `lcd_refresh` <= 1, `ref_cnt` <= REFRESH_CYCLES-1, go to REFRESH.
  - Otherwise `wr_en`: back[wr_addr] <= wr_char.
- CLEAR:
  - Each cycle back[clr_idx] <= CLEAR_CHAR and `clr_idx` increments.
  - After writing index 31, return to IDLE.
  - `wr_en`, `clear_req` and `commit_req` are ignored.
  - `data_out` is unchanged.
- REFRESH:
  - `lcd_refresh` stays high. At `ref_cnt`==0, drop `lcd_refresh` and go to IDLE; otherwise decrement.
  - `wr_en` is accepted into the back buffer, so the next frame can be composed while the LCD restarts.
  - `clear_req` and `commit_req` are ignored.
- Ignored requests are not queued. Requesters must wait for `busy`=0.
- Reset values:
  - back buffer all CLEAR_CHAR; `data_out` = {32{CLEAR_CHAR}}.
  - `busy`=0, `commit_done`=0, `lcd_refresh`=0.
  - state IDLE, `clr_idx`=0, `ref_cnt`=0.
  - The downstream driver therefore shows spaces after reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Timing
- Write: `wr_en` sampled at edge T. The back buffer holds the new value after T. No output changes.
- Commit: `commit_req` sampled in IDLE at edge T.
  - After T: `data_out` is new, `commit_done`=1, `lcd_refresh`=1, `busy`=1.
  - After T+1: `commit_done`=0.
  - `lcd_refresh` and `busy` stay high for exactly REFRESH_CYCLES cycles and fall together after edge T+REFRESH_CYCLES.
  - The first new `commit_req` accepted is at edge T+REFRESH_CYCLES+1.
- Clear: `clear_req` sampled in IDLE at edge T.
  - `busy`=1 after T; positions 0..31 are written at edges T+1..T+32.
  - `busy`=0 after T+32. Total 32 busy cycles.
- `busy` is a registered copy of (state != IDLE).
- Reset mid-clear leaves the whole buffer at CLEAR_CHAR. Reset mid-refresh drops `lcd_refresh` at once; `data_out` returns to spaces.
- Downstream note: the LCD driver's internal display clock is slow. REFRESH_CYCLES≥1 suffices because that driver's reset is asynchronous.

## Test plan
- Reset, then idle 5 cycles:
  - `data_out`=256'h2020…20, `busy`=0, `lcd_refresh`=0, `commit_done`=0.
- Write "HI" at addr 0,1 and 'Z' at addr 31, then `commit_req`:
  - next cycle `data_out[255:240]`=16'h4849, `data_out[7:0]`=8'h5A, remainder 8'h20.
  - `commit_done` is high for 1 cycle; `lcd_refresh` is high for 4 cycles.
- Same cycle `wr_en`(addr 5, 8'h41) and `commit_req` in IDLE:
  - committed `data_out[215:208]`=8'h41.
- `clear_req` with `wr_en` asserted for the next 32 cycles, then commit:
  - `busy` is high exactly 32 cycles; all writes are dropped; `data_out` is all 8'h20.
- Commit, then during REFRESH write 'X' at addr 16 and pulse `commit_req`:
  - the second `commit_req` is ignored (`commit_done` pulses once).
  - `data_out` is unchanged until a later commit, after which `data_out[127:120]`=8'h58.
- Assert `rst` low mid-clear (`clr_idx`≈10) and mid-refresh:
  - all outputs return to reset values asynchronously; `lcd_refresh` falls within the same cycle.
